spi_slave_resp: RTL and testbench

Responder end of the SPI link driven by the protocol controller's SPI master (sck/mosi/miso/ss pins); it sits in the SPI slave device model and in board-to-board bring-up.
- Oversamples the asynchronous SPI pins on the system clock.
- Shifts frames in and out, SPI mode 0, MSB first.
- Exchanges bytes with local logic through a tx valid/ready holding register and an rx valid/ready output register.

---
 rtl/spi_slave_resp.sv | 160 ++++++++++++++++
 tb/tb_spi_slave_resp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_resp.sv
// SPI mode-0 responder: pins oversampled on clk, SYNC_STAGES+1 cycles pin-to-action; tx holding register and
// rx output register with valid/ready. Define SPI_SLAVE_LSB_FIRST_EN to shift LSB first (default MSB first).
module spi_slave_resp #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    SYNC_STAGES   = 2,
  parameter logic [DATA_WIDTH-1:0] UNDERRUN_FILL = DATA_WIDTH'(8'hFF)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sck_ff, mosi_ff, ss_ff;
  logic                    sck_s, mosi_s, ss_s, sck_prev, ss_prev;
  logic                    sck_rise, sck_fall, ss_rise, ss_fall;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   tx_shift, rx_shift, hold_dat;
  logic                    hold_vld;
  logic                    tx_acc, do_load, fill;
  logic [DATA_WIDTH-1:0]   load_byte, tx_shift_nxt, rx_nxt;
  logic                    load_bit, shift_bit;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sck_ff   <= '0;
      mosi_ff  <= '0;
      ss_ff    <= '1;
      sck_prev <= 1'b0;
      ss_prev  <= 1'b1;
    end else begin
      sck_ff   <= {sck_ff[SYNC_STAGES-2:0], sck};
      mosi_ff  <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      ss_ff    <= {ss_ff[SYNC_STAGES-2:0], ss_n};
      sck_prev <= sck_s;
      ss_prev  <= ss_s;
    end
  end

  assign sck_s    = sck_ff[SYNC_STAGES-1];
  assign mosi_s   = mosi_ff[SYNC_STAGES-1];
  assign ss_s     = ss_ff[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign ss_rise  = ss_s & ~ss_prev;
  assign ss_fall  = ~ss_s & ss_prev;

  assign tx_ready = ~hold_vld;
  assign tx_acc   = tx_valid & tx_ready;
  assign do_load  = (state == LOAD) & ~ss_rise;
  // A byte arriving in the LOAD cycle goes straight to the shifter.
  assign fill      = ~hold_vld & ~tx_acc;
  assign load_byte = hold_vld ? hold_dat : (tx_acc ? tx_data : UNDERRUN_FILL);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign load_bit     = load_byte[0];
  assign shift_bit    = tx_shift[1];
  assign tx_shift_nxt = {1'b0, tx_shift[DATA_WIDTH-1:1]};
  assign rx_nxt       = {mosi_s, rx_shift[DATA_WIDTH-1:1]};
`else
  assign load_bit     = load_byte[DATA_WIDTH-1];
  assign shift_bit    = tx_shift[DATA_WIDTH-2];
  assign tx_shift_nxt = {tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign rx_nxt       = {rx_shift[DATA_WIDTH-2:0], mosi_s};
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (sck_rise && cnt == LAST) state_nxt = DONE;
      DONE:    if (sck_fall) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    if (ss_rise) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      miso_oe  <= 1'b0;
      miso     <= 1'b0;
      cnt      <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      hold_vld <= 1'b0;
      hold_dat <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_nxt;
      busy     <= (state_nxt != IDLE);
      miso_oe  <= (state_nxt != IDLE);
      overrun  <= 1'b0;
      underrun <= 1'b0;

      if (do_load) begin
        hold_vld <= 1'b0;
      end else if (tx_acc) begin
        hold_vld <= 1'b1;
        hold_dat <= tx_data;
      end

      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (do_load) begin
        tx_shift <= load_byte;
        miso     <= load_bit;
        cnt      <= '0;
        underrun <= fill;
      end else if (state == SHIFT && !ss_rise) begin
        if (sck_rise) begin
          rx_shift <= rx_nxt;
          if (cnt == LAST) begin
            cnt      <= '0;
            rx_data  <= rx_nxt;
            rx_valid <= 1'b1;
            // A same-cycle read frees the register, so only a stalled consumer loses data.
            overrun  <= rx_valid & ~rx_ready;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else if (sck_fall && cnt <= LAST) begin
          tx_shift <= tx_shift_nxt;
          miso     <= shift_bit;
        end
      end

      if (state_nxt == IDLE) begin
        miso     <= 1'b0;
        cnt      <= '0;
        tx_shift <= '0;
        rx_shift <= '0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_resp.sv
// Directed bench for spi_slave_resp: a mode-0 master at sck = clk/8 driving frames against hand-computed bytes.
module tb_spi_slave_resp;

  logic       clk = 1'b0;
  logic       nrst, sck, mosi, ss_n, miso, miso_oe;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, busy, overrun, underrun;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         hs_cyc = 0;
  int         und_cnt = 0;
  int         ovr_cnt = 0;
  logic [7:0] rxq[$];
  logic [7:0] rd;

  spi_slave_resp dut (
    .clk(clk), .nrst(nrst), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer side: log accepted frames and flag pulses just after each falling clk edge.
  always @(negedge clk) begin
    #1;
    if (nrst) begin
      if (rx_valid && rx_ready) begin
        rxq.push_back(rx_data);
        hs_cyc = cyc;
      end
      if (underrun) und_cnt++;
      if (overrun) ovr_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rx_at(input int i);
    return (rxq.size() > i) ? {24'h0, rxq[i]} : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_log();
    rxq.delete();
    und_cnt = 0;
    ovr_cnt = 0;
  endtask

  task automatic preload(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic ss_low();
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Clocks nbits out of b MSB first; with last set, ss_n rises together with the final sck fall.
  task automatic xfer(input logic [7:0] b, input int nbits, input bit last, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      repeat (4) @(negedge clk);
      got = {got[6:0], miso};
      sck = 1'b1;
      rise_cyc = cyc;
      repeat (4) @(negedge clk);
      sck = 1'b0;
      if (last && i == nbits - 1) ss_n = 1'b1;
    end
  endtask

  initial begin
    nrst = 1'b0; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_miso", miso, 1'b0);
    check("rst_miso_oe", miso_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx", {rx_valid, rx_data}, 9'h000);
    check("rst_flags", {busy, overrun, underrun}, 3'b000);
    nrst = 1'b1;
    repeat (4) @(negedge clk);

    // Preloaded byte goes out while 3C comes in.
    clear_log();
    preload(8'hA5);
    check("t1_hold_full", tx_ready, 1'b0);
    ss_low();
    check("t1_busy_oe", {busy, miso_oe}, 2'b11);
    check("t1_hold_moved", tx_ready, 1'b1);
    xfer(8'h3C, 8, 1'b1, rd);
    check("t1_miso", rd, 8'hA5);
    repeat (8) @(negedge clk);
    check("t1_rx_cnt", rxq.size(), 1);
    check("t1_rx", rx_at(0), 8'h3C);
    check("t1_rx_lat", (hs_cyc > rise_cyc) && (hs_cyc - rise_cyc <= 4), 1'b1);
    check("t1_underrun", und_cnt, 0);
    check("t1_idle", {busy, miso_oe}, 2'b00);

    // Nothing held: fill pattern goes out, one underrun.
    clear_log();
    ss_low();
    xfer(8'h01, 8, 1'b1, rd);
    repeat (8) @(negedge clk);
    check("t2_miso", rd, 8'hFF);
    check("t2_underrun", und_cnt, 1);
    check("t2_rx", rx_at(0), 8'h01);

    // Two frames under a single select.
    clear_log();
    preload(8'hC3);
    ss_low();
    preload(8'h5A);
    xfer(8'h11, 8, 1'b0, rd);
    check("t3_miso0", rd, 8'hC3);
    xfer(8'h22, 8, 1'b1, rd);
    check("t3_miso1", rd, 8'h5A);
    repeat (8) @(negedge clk);
    check("t3_rx_cnt", rxq.size(), 2);
    check("t3_rx0", rx_at(0), 8'h11);
    check("t3_rx1", rx_at(1), 8'h22);
    check("t3_underrun", und_cnt, 0);

    // Stalled consumer: second frame overwrites the first.
    clear_log();
    rx_ready = 1'b0;
    ss_low();
    xfer(8'h77, 8, 1'b1, rd);
    repeat (8) @(negedge clk);
    check("t4_first", {rx_valid, rx_data}, 9'h177);
    check("t4_no_ovr", ovr_cnt, 0);
    ss_low();
    xfer(8'h88, 8, 1'b1, rd);
    repeat (8) @(negedge clk);
    check("t4_overrun", ovr_cnt, 1);
    check("t4_second", {rx_valid, rx_data}, 9'h188);
    rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_rx_cnt", rxq.size(), 1);
    check("t4_rx", rx_at(0), 8'h88);
    check("t4_drained", rx_valid, 1'b0);

    // Select dropped after 5 bits: frame discarded, held byte kept for next frame.
    clear_log();
    ss_low();
    preload(8'h9E);
    xfer(8'hF0, 5, 1'b1, rd);
    repeat (8) @(negedge clk);
    check("t5_no_rx", rxq.size(), 0);
    check("t5_oe_off", miso_oe, 1'b0);
    check("t5_hold_kept", tx_ready, 1'b0);
    ss_low();
    xfer(8'h4B, 8, 1'b1, rd);
    repeat (8) @(negedge clk);
    check("t5_miso", rd, 8'h9E);
    check("t5_rx", rx_at(0), 8'h4B);

    // Asynchronous reset in the middle of a frame.
    clear_log();
    ss_low();
    preload(8'h66);
    xfer(8'hAA, 3, 1'b0, rd);
    nrst = 1'b0; ss_n = 1'b1; sck = 1'b0;
    #1;
    check("t6_rst_tx_ready", tx_ready, 1'b1);
    check("t6_rst_rx", {rx_valid, rx_data}, 9'h000);
    check("t6_rst_out", {busy, miso_oe, miso}, 3'b000);
    @(negedge clk);
    nrst = 1'b1;
    repeat (8) @(negedge clk);
    clear_log();
    preload(8'h2D);
    ss_low();
    xfer(8'hD2, 8, 1'b1, rd);
    repeat (8) @(negedge clk);
    check("t6_miso", rd, 8'h2D);
    check("t6_rx", rx_at(0), 8'hD2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
